// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity modes and
// default frame geometry used by both transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int NBITS_DEF  = 8;
  localparam int NTICKB_DEF = 16;
  localparam int NSTOP_DEF  = 32;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_holdreg.sv
// One-entry holding buffer in front of the UART serializer.
// Captures a word on accept, releases it on load.
module uart_tx_holdreg
  import uart_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             accept_i,
  input  logic             load_i,
  input  logic [NBITS-1:0] data_i,
  output logic             buf_valid_o,
  output logic [NBITS-1:0] buf_data_o,
  output logic             ready_o
);

  logic             valid_q;
  logic [NBITS-1:0] data_q;

  // accept needs an empty buffer and load a full one, so the
  // accept branch taking priority only matters for robustness
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (accept_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (load_i) begin
      valid_q <= 1'b0;
    end
  end

  assign buf_valid_o = valid_q;
  assign buf_data_o  = data_q;
  assign ready_o     = !valid_q;

endmodule

// File: rtl/uart_tx_ser.sv
// UART serializer: start bit, LSB-first data, optional parity,
// stop period; clocked by the oversampling baud tick.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int NBITS       = NBITS_DEF,
  parameter int NTICKB      = NTICKB_DEF,
  parameter int NSTOP_TICKS = NSTOP_DEF,
  parameter int PARITY      = PAR_NONE
) (
  input  logic             bdtick,
  input  logic             tx_rst,
  input  logic             tx_start,
  input  logic [NBITS-1:0] tx_in,
  output logic             tx_ready,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_out
);

  localparam int SW = $clog2(max2(NTICKB, NSTOP_TICKS));
  localparam int IW = $clog2(NBITS);

  localparam logic [SW-1:0] S_BIT  = SW'(NTICKB - 1);
  localparam logic [SW-1:0] S_STOP = SW'(NSTOP_TICKS - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [IW-1:0] I_LAST = IW'(NBITS - 1);
  localparam logic [IW-1:0] I_ONE  = IW'(1);

  if (NTICKB < 2) begin : g_chk_ntickb
    $error("uart_tx_ser: NTICKB must be >= 2");
  end
  if (NSTOP_TICKS < 1) begin : g_chk_nstop
    $error("uart_tx_ser: NSTOP_TICKS must be >= 1");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("uart_tx_ser: PARITY must be 0, 1 or 2");
  end
  if (NBITS < 5) begin : g_chk_nbits
    $error("uart_tx_ser: NBITS must be >= 5");
  end

  tx_state_e        state_q;
  logic [SW-1:0]    s_q;
  logic [IW-1:0]    i_q;
  logic [NBITS-1:0] sh_q;
  logic             par_q;
  logic             out_q;
  logic             done_q;

  logic             buf_valid;
  logic [NBITS-1:0] buf_data;
  logic             accept;
  logic             load;
  logic             stop_end;

  assign accept   = tx_start && tx_ready;
  assign stop_end = (state_q == ST_STOP) && (s_q == S_STOP);
  assign load     = buf_valid && ((state_q == ST_IDLE) || stop_end);

  uart_tx_holdreg #(
    .NBITS(NBITS)
  ) u_hold (
    .clk_i      (bdtick),
    .rst_i      (tx_rst),
    .accept_i   (accept),
    .load_i     (load),
    .data_i     (tx_in),
    .buf_valid_o(buf_valid),
    .buf_data_o (buf_data),
    .ready_o    (tx_ready)
  );

  always_ff @(posedge bdtick) begin
    if (tx_rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      i_q     <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        // a load on the last stop tick still closes the old frame
        done_q  <= stop_end;
        state_q <= ST_START;
        s_q     <= '0;
        i_q     <= '0;
        sh_q    <= buf_data;
        par_q   <= (PARITY == PAR_ODD) ? ~^buf_data : ^buf_data;
        out_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            out_q <= 1'b1;
          end
          ST_START: begin
            if (s_q == S_BIT) begin
              s_q     <= '0;
              i_q     <= '0;
              out_q   <= sh_q[0];
              state_q <= ST_DATA;
            end else begin
              s_q <= s_q + S_ONE;
            end
          end
          ST_DATA: begin
            if (s_q == S_BIT) begin
              s_q <= '0;
              if (i_q != I_LAST) begin
                i_q   <= i_q + I_ONE;
                sh_q  <= sh_q >> 1;
                out_q <= sh_q[1];
              end else if (PARITY != PAR_NONE) begin
                out_q   <= par_q;
                state_q <= ST_PARITY;
              end else begin
                out_q   <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              s_q <= s_q + S_ONE;
            end
          end
          ST_PARITY: begin
            if (s_q == S_BIT) begin
              s_q     <= '0;
              out_q   <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              s_q <= s_q + S_ONE;
            end
          end
          ST_STOP: begin
            if (s_q == S_STOP) begin
              s_q     <= '0;
              done_q  <= 1'b1;
              out_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              s_q <= s_q + S_ONE;
            end
          end
          default: begin
            out_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_busy = (state_q != ST_IDLE);
  assign tx_done = done_q;
  assign tx_out  = out_q;

endmodule

// File: doc/uart_tx_ser.md
Name: uart_tx_ser

Overview:
UART serializer: converts a parallel NBITS word into an asynchronous serial frame on tx_out (start bit, data LSB first, optional parity, stop). Clocked directly by the oversampling baud tick bdtick, so one clock cycle equals one oversample tick and one bit lasts NTICKB cycles. A one-entry holding register accepts the next word while the current frame is on the line, so frames can be sent back-to-back with no idle gap. The frame format is compatible with the team's oversampling UART receiver.

Parameters:
NBITS, 8, data bits per frame
NTICKB, 16, bdtick cycles per start/data/parity bit
NSTOP_TICKS, 32, bdtick cycles the line is held high for stop (32 = two stop bits)
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
bdtick  in  1  clock (oversample baud tick)
tx_rst  in  1  reset; synchronous, active-high
tx_start  in  1  word-valid strobe, sampled on bdtick rising edge
tx_in  in  NBITS  word to send; captured when tx_start && tx_ready
tx_ready  out  1  holding register empty; tx_start accepted this cycle
tx_busy  out  1  frame in progress (state != IDLE)
tx_done  out  1  one-cycle pulse: the last stop tick has completed
tx_out  out  1  serial line, registered, idles high

Behaviour:
- Reset is sampled on bdtick only (synchronous, active-high). While tx_rst=1: state=IDLE, tx_out=1, tx_ready=1 (buffer empty), tx_busy=0, tx_done=0, all counters 0. tx_start is ignored during reset.
- Reset mid-frame: tx_out=1 from the first edge with tx_rst=1. The frame is aborted and the buffered word is discarded. No tx_done is produced.
- Accept: at an edge with tx_start=1 and tx_ready=1, tx_in goes into the holding register and buf_valid is set. tx_start while tx_ready=0 is ignored; the buffered word is never overwritten.
- Load: a word is loaded into the shift register on the edge where buf_valid=1 and the FSM is in IDLE, or is leaving STOP. On that edge: state<=START, tick counter s<=0, tx_out<=0, buf_valid<=0. If an accept happens on the same edge, the new word wins and buf_valid stays 1.
- Latency: accept at edge k, load at edge k+1, tx_out low starting after edge k+1.
- START: tx_out=0 for NTICKB cycles (s counts 0..NTICKB-1). At s==NTICKB-1: s<=0, bit index i<=0, tx_out<=data[0], go to DATA.
- DATA: each bit is held for NTICKB cycles. At s==NTICKB-1: if i<NBITS-1, then i<=i+1 and tx_out<=data[i+1]. Otherwise go to PARITY (PARITY!=0) or STOP.
- PARITY: even gives the XOR of all data bits; odd gives the inverted XOR. Held for NTICKB cycles, then go to STOP.
- STOP: tx_out=1 for NSTOP_TICKS cycles. On the final tick: tx_done<=1 for one cycle. Then load the next word if buf_valid=1, otherwise go to IDLE with tx_out=1.
- Frame length is NTICKB*(1+NBITS+(PARITY!=0)) + NSTOP_TICKS cycles, measured from the load edge to the edge that asserts tx_done.
- Counter widths: s is $clog2(max(NTICKB,NSTOP_TICKS)) bits. i is $clog2(NBITS) bits. Compares use exact terminal values, so counters never wrap.
- tx_ready = !buf_valid, combinational from the register. tx_busy = (state!=IDLE), registered state decode.
- Elaboration checks: NTICKB>=2, NSTOP_TICKS>=1, PARITY in {0,1,2}, NBITS>=5.

Decomposition:
- Package uart_pkg holds:
  - the state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3-bit);
  - PARITY encodings: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - default NBITS and NTICKB, shared with the receiver.
- One sub-module, uart_tx_holdreg: the one-entry buffer. It takes the accept and load strobes and drives buf_valid, buf_data and tx_ready.
- FSM, counters and shift register stay in uart_tx_ser.

Test Plan:
- All tests use the defaults: NBITS=8, NTICKB=16, NSTOP_TICKS=32, PARITY=0.
- Reset held 3 cycles, then released -> tx_out=1, tx_ready=1, tx_busy=0, tx_done=0. The line stays high for 50 idle cycles.
- Send 0xA5 -> after the load edge: tx_out=0 for 16 cycles, then 1,0,1,0,0,1,0,1 each for 16 cycles, then high for 32 cycles. tx_done pulses exactly 176 cycles after the load edge. tx_busy=0 on the next cycle.
- Send 0x55, then 0x0F accepted 5 cycles later -> the 0x0F start bit begins on the cycle right after the last 0x55 stop tick (no idle gap). tx_ready=0 from the second accept until that load. Two tx_done pulses, 176 cycles apart.
- With PARITY=1, send 0x07 -> parity bit 1. With PARITY=2 -> parity bit 0. Frame length 192 cycles.
- Send 0xFF with 0x3C buffered, then assert tx_rst 40 cycles after the load -> tx_out=1 from the next edge, tx_busy=0, tx_ready=1. 0x3C is never transmitted and no tx_done occurs.
- Hold tx_start high with tx_in=0x11, then 0x22, while tx_ready=0 -> the words offered while tx_ready=0 are not captured. Only the word accepted while the buffer was empty is sent after the current frame.
